riscv_prefetch_feeder: RTL
==========================

# riscv_prefetch_feeder

Instruction prefetcher that sits between the instruction-memory port and the instruction aligner. It issues word-aligned fetch requests on an OBI-style req/gnt/rvalid bus and buffers returned words in a FIFO. It presents the words to the aligner as `fetch_valid_o`/`fetch_rdata_o`, honours the aligner's raw-instruction hold, and flushes and redirects on branches.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `req_i  in  1`: fetch enable; when low, no new requests are issued.
- `branch_i  in  1`: redirect strobe (one cycle).
- `branch_addr_i  in  32`: redirect target; bits [1:0] ignored for the bus address.
- `fetch_valid_o  out  1`: head word valid.
- `fetch_rdata_o  out  32`: head word.
- `fetch_ready_i  in  1`: aligner consumes the head this cycle.
- `raw_instr_hold_i  in  1`: aligner could not consume the presented word; keep it at the head.
- `fetch_err_o  out  1`: head word carries a bus error (see Configuration).
- `instr_req_o  out  1`, `instr_addr_o  out  32`: bus request and word address.
- `instr_gnt_i  in  1`, `instr_rvalid_i  in  1`, `instr_rdata_i  in  32`, `instr_err_i  in  1`: bus grant and response.

## Operation
- Pop = `fetch_valid_o & fetch_ready_i & ~raw_instr_hold_i`. Push = `instr_rvalid_i & (discard_cnt==0)`.
- `fetch_valid_o` = FIFO not empty. `fetch_rdata_o` = FIFO head. There is no bypass.
- Credit rule: a request may be issued only when `occupancy + outstanding < DEPTH`; the FIFO therefore never overflows.
- `outstanding` counter, max 2, 2 bits: +1 on `req&gnt`, −1 on `rvalid`. No request is issued while `outstanding==2`.
- `fetch_addr` register: +4 on each grant.
- FSM states:
  - IDLE: `instr_req_o=0`. Go to FETCH when `req_i`.
  - FETCH: `instr_req_o = req_i & credit & outstanding<2`. Go to IDLE when `!req_i` and no request is pending without grant.
  - BRANCH_PEND: redirect is waiting behind an ungranted request.
- Branch handling:
  - FIFO flushed the same cycle.
  - `discard_cnt` ← number of responses still owed, i.e. `outstanding` plus 1 if `req&gnt` this cycle, minus 1 if `rvalid` this cycle.
  - Each discarded `rvalid` decrements `discard_cnt`.
  - `fetch_addr` ← `{branch_addr_i[31:2],2'b00}`.
- OBI stability: once `instr_req_o` is high without grant, `instr_addr_o` is held. A branch in that state enters BRANCH_PEND. The old request completes and its response is discarded, then the new address is issued. Return to FETCH on that grant.
- A second branch while in BRANCH_PEND overwrites the pending target.
- Branch wins over hold and pop in the same cycle.
- `rvalid` in the same cycle as `branch_i` is dropped.
- `req&gnt` in the same cycle as `branch_i` is counted into `discard_cnt`.

## Timing
- Reset values:
  - `instr_req_o=0`, `instr_addr_o=0`
  - `fetch_valid_o=0`, `fetch_rdata_o=0`, `fetch_err_o=0`
  - FSM=IDLE, all counters 0
- The boot address is supplied by a `branch_i` after reset.
- Latency:
  - `branch_i` → `instr_req_o` with the new address: next cycle, if no ungranted request is pending.
  - `rvalid` → `fetch_valid_o`: 1 cycle.
  - Branch → first valid word: 2 cycles after grant with zero-wait memory.
- Hold: the head stays unchanged for as long as `raw_instr_hold_i` is high.
- Full FIFO with pop and push in the same cycle: both are performed.
- Reset mid-transaction: all state is cleared. Stray bus responses after reset are a memory-side violation and are not handled.

## Configuration
- `RISCV_FETCH_ERR_EN` defined:
  - FIFO is 33 bits wide and stores `instr_err_i` with each word.
  - `fetch_err_o` = error bit of the head entry.
  - After an error response is pushed, no new requests are issued until `branch_i`.
- `RISCV_FETCH_ERR_EN` undefined:
  - FIFO is 32 bits wide; `instr_err_i` is ignored.
  - `fetch_err_o` is tied 0; fetching continues regardless of bus errors.

## Structure
- `riscv_prefetch_pkg` holds:
  - the FSM state enum (IDLE, FETCH, BRANCH_PEND)
  - `MAX_OUTSTANDING=2`
  - the FIFO entry struct (`rdata`, plus `err` under the macro)
- Sub-module `riscv_fetch_fifo` implements the synchronous FIFO:
  - parameters `DEPTH` and `WIDTH`
  - ports: push, pop, flush, full, empty, occupancy, head
  - flush takes priority over push.

## Test plan
- Zero-wait memory, `branch_addr_i=0x100`, `req_i=1`:
  - addresses 0x100, 0x104, … issued back to back
  - `fetch_valid_o` 2 cycles after the first grant, with the words in order.
- `fetch_ready_i=0` with DEPTH=4: at most 4 words held; `instr_req_o` deasserts once occupancy + outstanding = 4.
- `raw_instr_hold_i=1` for 3 cycles with the head at 0xDEAD0013: the head stays 0xDEAD0013 and occupancy is unchanged.
- Branch to 0x202 with 2 outstanding:
  - both stale responses are dropped
  - the next request address is 0x200
  - the first pushed word comes from 0x200.
- Request at 0x104 waiting without grant, then branch to 0x400:
  - `instr_addr_o` stays 0x104 until grant
  - 0x104's response is discarded
  - then 0x400 is issued.
- With `RISCV_FETCH_ERR_EN`, error response on 0x108:
  - `fetch_err_o=1` when that word is at the head
  - no further requests until a branch to 0x300, after which fetching resumes.

Source files
------------

// File: rtl/riscv_prefetch_pkg.sv
// Shared types for the instruction prefetcher; the FIFO entry gains an error bit
// when RISCV_FETCH_ERR_EN is defined.
package riscv_prefetch_pkg;

   localparam int MAX_OUTSTANDING = 2;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      BRANCH_PEND
   } fetch_state_e;

   typedef struct packed {
`ifdef RISCV_FETCH_ERR_EN
      logic        err;
`endif
      logic [31:0] rdata;
   } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO, head visible the cycle after the push; no bypass.
// Flush beats push; push into a full FIFO is accepted only alongside a pop.
module riscv_fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [WIDTH-1:0]         head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (occupancy == '0);
   assign full    = (occupancy == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         occupancy <= occupancy + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/riscv_prefetch_feeder.sv
// OBI instruction prefetcher: rvalid->fetch_valid 1 cycle, credit-limited issue, flush/redirect on branch.
// RISCV_FETCH_ERR_EN: store bus errors per word and stop issuing after an error until the next branch.
module riscv_prefetch_feeder
   import riscv_prefetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_rdata_o,
   input  logic        fetch_ready_i,
   input  logic        raw_instr_hold_i,
   output logic        fetch_err_o,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 2;

   fetch_state_e  state;
   logic [31:0]   fetch_addr;
   logic [31:0]   tgt_addr;
   logic [31:0]   target;
   logic [1:0]    outstanding;
   logic [1:0]    out_next;
   logic [1:0]    discard_cnt;
   logic          pend;
   logic          stop;
   logic          credit;
   logic          issue_ok;
   logic          gnt_hs;
   logic          push;
   logic          pop;
   logic          empty;
   logic          full;
   logic [AW:0]   occupancy;
   fetch_entry_t  wr_entry;
   fetch_entry_t  head;

   assign target   = {branch_addr_i[31:2], 2'b00};
   assign credit   = (CW'(occupancy) + CW'(outstanding)) < CW'(DEPTH);
   assign issue_ok = req_i & credit & (outstanding < 2'(MAX_OUTSTANDING)) & ~stop;
   assign gnt_hs   = instr_req_o & instr_gnt_i;
   assign out_next = outstanding + 2'(gnt_hs) - 2'(instr_rvalid_i);

   // An ungranted request must stay up with a stable address regardless of req_i/credit.
   always_comb begin
      instr_req_o = 1'b0;
      case (state)
         FETCH:       instr_req_o = pend | issue_ok;
         BRANCH_PEND: instr_req_o = 1'b1;
         default:     instr_req_o = 1'b0;
      endcase
   end
   assign instr_addr_o = fetch_addr;

   assign push = instr_rvalid_i & (discard_cnt == 2'd0) & ~branch_i;
   assign pop  = fetch_valid_o & fetch_ready_i & ~raw_instr_hold_i & ~branch_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fetch_addr <= '0;
         tgt_addr   <= '0;
         pend       <= 1'b0;
      end else begin
         pend <= instr_req_o & ~instr_gnt_i;
         if (gnt_hs) fetch_addr <= fetch_addr + 32'd4;
         case (state)
            IDLE: begin
               if (branch_i) fetch_addr <= target;
               if (req_i)    state      <= FETCH;
            end
            FETCH: begin
               if (branch_i) begin
                  if (instr_req_o && !instr_gnt_i) begin
                     tgt_addr <= target;
                     state    <= BRANCH_PEND;
                  end else begin
                     fetch_addr <= target;
                     state      <= req_i ? FETCH : IDLE;
                  end
               end else if (!req_i && !(instr_req_o && !instr_gnt_i)) begin
                  state <= IDLE;
               end
            end
            BRANCH_PEND: begin
               if (instr_gnt_i) begin
                  fetch_addr <= branch_i ? target : tgt_addr;
                  state      <= FETCH;
               end else if (branch_i) begin
                  tgt_addr <= target;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The stale request granted in BRANCH_PEND adds one more response to drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
         discard_cnt <= '0;
      end else begin
         outstanding <= out_next;
         if (branch_i)
            discard_cnt <= out_next;
         else
            discard_cnt <= discard_cnt
                           - 2'(instr_rvalid_i && discard_cnt != 2'd0)
                           + 2'(state == BRANCH_PEND && instr_gnt_i);
      end
   end

`ifdef RISCV_FETCH_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   stop <= 1'b0;
      else if (branch_i)            stop <= 1'b0;
      else if (push && instr_err_i) stop <= 1'b1;
   end
   assign wr_entry    = '{err: instr_err_i, rdata: instr_rdata_i};
   assign fetch_err_o = head.err;
`else
   logic unused_err;
   assign stop        = 1'b0;
   assign wr_entry    = '{rdata: instr_rdata_i};
   assign fetch_err_o = 1'b0;
   assign unused_err  = instr_err_i;
`endif

   logic unused_bits;
   assign unused_bits = &{1'b0, full, branch_addr_i[1:0]};

   riscv_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .wdata     (wr_entry),
      .pop       (pop),
      .flush     (branch_i),
      .full      (full),
      .empty     (empty),
      .occupancy (occupancy),
      .head      (head)
   );

   assign fetch_valid_o = ~empty;
   assign fetch_rdata_o = head.rdata;

endmodule
